// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// default geometry, and the byte-lane mapping helper.
// Optional build macro: FETCH_BIG_ENDIAN_EN selects big-endian lane placement.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACKWAIT,
    DRAIN
  } fetchState_t;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned BYTES_DEF  = 4;

  // Map the k-th fetched byte (from pc+k) to its lane in the assembled word.
  function automatic int unsigned laneIdx(input int unsigned k, input int unsigned nBytes);
`ifdef FETCH_BIG_ENDIAN_EN
    return nBytes - 1 - k;
`else
    return (k < nBytes) ? k : 0;
`endif
  endfunction

endpackage

// File: rtl/fetch_unit_toggle_detect.sv
// Toggle-style request detector: remembers the last acknowledged level of a
// toggling request line and flags a pending request whenever they differ.
module toggle_detect (
  input  logic clk,
  input  logic rst,
  input  logic sigIn,
  input  logic load,
  output logic pending
);

  logic seen;

  // Reset and load both re-arm on the current line level, dropping any toggle.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      seen <= sigIn;
    end
  end

  assign pending = (sigIn != seen);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: on each triggerIn toggle, reads BYTES bytes from a
// byte-wide memory over a readyIn/triggerOut toggle handshake, assembles them
// into dataOut and presents pcOut = pc + BYTES with readyOut.
// Optional build macro: FETCH_BIG_ENDIAN_EN (big-endian byte lanes).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned BYTES  = BYTES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              triggerIn,
  input  logic [ADDR_W-1:0] pcIn,
  output logic [ADDR_W-1:0] addrOut,
  input  logic [7:0]        dataIn,
  input  logic              readyIn,
  output logic              triggerOut,
  output logic [8*BYTES-1:0] dataOut,
  output logic              readyOut,
  output logic [ADDR_W-1:0] pcOut
);

  localparam int unsigned IDX_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned DATA_W = 8 * BYTES;

  fetchState_t       state, nextState;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  lane;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] word, wordNext;
  logic              pending, startFetch, captureByte, advance, lastByte;

  toggle_detect uTrig (
    .clk     (clk),
    .rst     (rst),
    .sigIn   (triggerIn),
    .load    (startFetch),
    .pending (pending)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic: each byte needs a readyIn high (REQ) then low (ACKWAIT).
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (pending) nextState = REQ;
      REQ:     if (readyIn) nextState = lastByte ? DRAIN : ACKWAIT;
      ACKWAIT: if (!readyIn) nextState = REQ;
      DRAIN:   if (!readyIn) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Output/control strobes decoded from the current state.
  always_comb begin
    startFetch  = 1'b0;
    captureByte = 1'b0;
    advance     = 1'b0;
    lastByte    = (idx == IDX_W'(BYTES - 1));
    unique case (state)
      IDLE:    startFetch  = pending;
      REQ:     captureByte = readyIn;
      ACKWAIT: advance     = !readyIn;
      default: ;
    endcase
  end

  // Merge the incoming byte into its lane of the shadow word.
  always_comb begin
    lane     = IDX_W'(laneIdx(32'(idx), BYTES));
    wordNext = word;
    wordNext[{lane, 3'b000} +: 8] = dataIn;
  end

  // Datapath registers. Bytes assemble in a shadow word so dataOut only
  // changes on completion and a reset mid-fetch discards the partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      addrOut    <= '0;
      dataOut    <= '0;
      pcOut      <= '0;
      triggerOut <= 1'b0;
      readyOut   <= 1'b0;
      idx        <= '0;
      pc         <= '0;
      word       <= '0;
    end else begin
      if (startFetch) begin
        pc       <= pcIn;
        addrOut  <= pcIn;
        idx      <= '0;
        readyOut <= 1'b0;
      end
      if (captureByte) begin
        word       <= wordNext;
        triggerOut <= ~triggerOut;
        if (lastByte) begin
          dataOut  <= wordNext;
          readyOut <= 1'b1;
          pcOut    <= pc + ADDR_W'(BYTES);
        end
      end
      if (advance) begin
        idx     <= idx + 1'b1;
        addrOut <= pc + ADDR_W'(idx) + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: table of fetch vectors served by a byte-memory model,
// completions checked against a scoreboard queue, plus reset corner cases.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        triggerIn;
  logic [31:0] pcIn;
  logic [31:0] addrOut;
  logic [7:0]  dataIn;
  logic        readyIn;
  logic        triggerOut;
  logic [31:0] dataOut;
  logic        readyOut;
  logic [31:0] pcOut;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(32), .BYTES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .triggerIn  (triggerIn),
    .pcIn       (pcIn),
    .addrOut    (addrOut),
    .dataIn     (dataIn),
    .readyIn    (readyIn),
    .triggerOut (triggerOut),
    .dataOut    (dataOut),
    .readyOut   (readyOut),
    .pcOut      (pcOut)
  );

  int total = 0;
  int bad   = 0;
  int trigCount = 0;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    int          hold;
    bit          toggleStart;
    int          midToggles;
    logic [31:0] expLE;
    logic [31:0] expBE;
    logic [31:0] expPc;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[9];
  vec_t extra;
  logic prevReady = 1'b0;

  // Memory model: byte at address a holds a[7:0]+1 (so mem[0..3] = 01..04).
  function automatic logic [7:0] memByte(input logic [31:0] a);
    return a[7:0] + 8'd1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(triggerOut) trigCount++;

  // Scoreboard: every readyOut rise must match the oldest pushed expectation.
  always @(negedge clk) begin
    exp_t e;
    if (readyOut === 1'b1 && prevReady !== 1'b1) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious completion: actual=readyOut rise, dataOut=0x%08h required=no completion", dataOut);
      end else begin
        e = sbq.pop_front();
        check("dataOut", dataOut, e.data);
        check("pcOut", pcOut, e.pc);
      end
    end
    prevReady = readyOut;
  end

  task automatic runFetch(input vec_t v);
    logic [31:0] a;
    int          c0;
    exp_t        e;
    pcIn = v.pc;
    if (v.toggleStart) triggerIn = ~triggerIn;
`ifdef FETCH_BIG_ENDIAN_EN
    e.data = v.expBE;
`else
    e.data = v.expLE;
`endif
    e.pc = v.expPc;
    sbq.push_back(e);
    step();
    check("readyOut low at start", 32'(readyOut), 32'd0);
    for (int k = 0; k < 4; k++) begin
      a = v.pc + 32'(k);
      check("addrOut", addrOut, a);
      c0 = trigCount;
      dataIn  = memByte(a);
      readyIn = 1'b1;
      repeat (v.hold) step();
      check("triggerOut toggles per byte", 32'(trigCount - c0), 32'd1);
      readyIn = 1'b0;
      step();
      if (k == 1) begin
        for (int t = 0; t < v.midToggles; t++) begin
          triggerIn = ~triggerIn;
          step();
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; triggerIn = 1'b0; pcIn = '0; dataIn = '0; readyIn = 1'b0;

    //            pc            hold tog mid expLE         expBE         expPc
    vecs[0] = '{32'h0000_0000, 1, 1'b1, 0, 32'h04030201, 32'h01020304, 32'h0000_0004};
    vecs[1] = '{32'h0000_0004, 1, 1'b1, 0, 32'h08070605, 32'h05060708, 32'h0000_0008};
    vecs[2] = '{32'h0000_0020, 5, 1'b1, 0, 32'h24232221, 32'h21222324, 32'h0000_0024};
    vecs[3] = '{32'h0000_0040, 2, 1'b1, 1, 32'h44434241, 32'h41424344, 32'h0000_0044};
    vecs[4] = '{32'h0000_0080, 1, 1'b0, 0, 32'h84838281, 32'h81828384, 32'h0000_0084};
    vecs[5] = '{32'h0000_0100, 1, 1'b1, 2, 32'h04030201, 32'h01020304, 32'h0000_0104};
    vecs[6] = '{32'hFFFF_FFFC, 1, 1'b1, 0, 32'h00FFFEFD, 32'hFDFEFF00, 32'h0000_0000};
    vecs[7] = '{32'hFFFF_FFFE, 1, 1'b1, 0, 32'h020100FF, 32'hFF000102, 32'h0000_0002};
    vecs[8] = '{32'h0000_0013, 1, 1'b1, 0, 32'h17161514, 32'h14151617, 32'h0000_0017};

    repeat (2) step();
    check("reset addrOut", addrOut, 32'd0);
    check("reset dataOut", dataOut, 32'd0);
    check("reset pcOut", pcOut, 32'd0);
    check("reset triggerOut", 32'(triggerOut), 32'd0);
    check("reset readyOut", 32'(readyOut), 32'd0);
    rst = 1'b0;
    step();
    check("idle addrOut", addrOut, 32'd0);
    trigCount = 0;

    for (int i = 0; i < 9; i++) begin
      runFetch(vecs[i]);
      check("readyOut held after drain", 32'(readyOut), 32'd1);
      if (vecs[i].midToggles == 2) begin
        repeat (3) step();
        check("even toggles: no new fetch addrOut", addrOut, vecs[i].pc + 32'd3);
        check("even toggles: readyOut held", 32'(readyOut), 32'd1);
      end
    end

    // Reset after two bytes of a fetch: everything returns to reset values.
    pcIn = 32'h0000_0200;
    triggerIn = ~triggerIn;
    step();
    for (int k = 0; k < 2; k++) begin
      dataIn  = memByte(32'h0000_0200 + 32'(k));
      readyIn = 1'b1;
      step();
      readyIn = 1'b0;
      step();
    end
    check("pre-reset addrOut", addrOut, 32'h0000_0202);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid-fetch reset addrOut", addrOut, 32'd0);
    check("mid-fetch reset dataOut", dataOut, 32'd0);
    check("mid-fetch reset pcOut", pcOut, 32'd0);
    check("mid-fetch reset triggerOut", 32'(triggerOut), 32'd0);
    check("mid-fetch reset readyOut", 32'(readyOut), 32'd0);
    repeat (2) step();
    check("post-reset idle addrOut", addrOut, 32'd0);
    check("post-reset readyOut", 32'(readyOut), 32'd0);
    extra = '{32'h0000_0010, 1, 1'b1, 0, 32'h14131211, 32'h11121314, 32'h0000_0014};
    runFetch(extra);

    // Toggle coincident with reset is dropped.
    pcIn = 32'h0000_0300;
    triggerIn = ~triggerIn;
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) step();
    check("reset+toggle addrOut", addrOut, 32'd0);
    check("reset+toggle readyOut", 32'(readyOut), 32'd0);

    // Fetch still works afterwards.
    runFetch(vecs[0]);
    step();

    check("scoreboard drained", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the ARM core pipeline.
- A toggle on triggerIn requests one 32-bit instruction at pcIn.
- The block reads 4 bytes from a byte-wide memory over a readyIn/triggerOut handshake and assembles them into dataOut.
- On completion it asserts readyOut with pcOut = pc+4 for the decode stage.

Parameters:
- ADDR_W, 32, width of pcIn/pcOut/addrOut.
- BYTES, 4, bytes per instruction word; dataOut width = 8*BYTES.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- triggerIn  in  1  fetch request; every toggle (either edge) is one request.
- pcIn  in  ADDR_W  fetch address, sampled when the request starts.
- addrOut  out  ADDR_W  byte address presented to memory.
- dataIn  in  8  memory byte for addrOut.
- readyIn  in  1  memory strobe; high = dataIn valid for current addrOut.
- triggerOut  out  1  toggles once per accepted byte (ack to memory).
- dataOut  out  8*BYTES  assembled instruction.
- readyOut  out  1  high = dataOut/pcOut valid.
- pcOut  out  ADDR_W  next PC = latched pc + BYTES.

Behaviour:
- Reset (synchronous, active-high):
  - Outputs: addrOut=0, dataOut=0, pcOut=0, triggerOut=0, readyOut=0.
  - Internal: state=IDLE, byte index=0, trig_seen=triggerIn sampled at reset.
- States: IDLE, REQ, ACKWAIT, DRAIN.
- IDLE:
  - Start condition: triggerIn != trig_seen.
  - Next edge: trig_seen<=triggerIn, pc<=pcIn, addrOut<=pcIn, idx<=0, readyOut<=0, go to REQ.
- REQ:
  - When readyIn=1, capture dataIn into byte lane idx and toggle triggerOut on the same edge.
  - If idx<BYTES-1: go to ACKWAIT.
  - If idx=BYTES-1: readyOut<=1 and pcOut<=pc+BYTES (mod 2^ADDR_W) with the final triggerOut toggle, then go to DRAIN.
- ACKWAIT:
  - Hold addrOut until readyIn=0.
  - Then idx<=idx+1, addrOut<=pc+idx+1 (mod 2^ADDR_W), go to REQ.
  - readyIn held high never captures a byte twice.
- DRAIN: when readyIn=0, go to IDLE.
- Latency: request visible at addrOut 1 cycle after the toggle is sampled. Each byte takes at least 2 cycles (REQ + ACKWAIT). readyOut rises with the 4th triggerOut toggle.
- Byte order: little-endian. The byte from pc+k lands in dataOut[8k+7:8k].
- Output hold:
  - dataOut and pcOut hold until the next completion.
  - readyOut stays high until the next fetch starts.
- Requests during REQ/ACKWAIT/DRAIN:
  - trig_seen is not updated, so a single toggle stays pending and is serviced on return to IDLE.
  - An even number of toggles cancels out.
- Unaligned pcIn is legal; addresses are used as-is.
- Wrap: pcIn=0xFFFFFFFE reads FFFFFFFE, FFFFFFFF, 0, 1; pcOut=2.
- Reset mid-fetch: immediate return to reset values; partial word discarded.
- Simultaneous reset and request: reset wins; trig_seen<=triggerIn, so the toggle is dropped.

Optional Feature:
- Macro: FETCH_BIG_ENDIAN_EN.
- Defined: the byte from pc+k lands in dataOut[8*(BYTES-1-k)+7 -: 8]. Memory 01,02,03,04 gives 0x01020304.
- Undefined: little-endian as above, giving 0x04030201.
- No other behaviour changes.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum (IDLE, REQ, ACKWAIT, DRAIN);
  - ADDR_W and BYTES defaults;
  - a lane-index function (endianness select).
- One natural sub-module: toggle_detect (trig_seen register plus compare, with a load enable), reusable by other async-style stages.

Test Plan:
- Basic fetch:
  - Stimulus: mem[0..3]=01,02,03,04, pcIn=0, toggle triggerIn, serve each addrOut with readyIn pulses.
  - Response: addrOut sequence 0,1,2,3; four triggerOut toggles; readyOut=1; dataOut=0x04030201; pcOut=4.
- Back-to-back fetch:
  - Stimulus: after DRAIN, pcIn=4 with a new toggle.
  - Response: readyOut drops on start; addrOut 4..7; pcOut=8.
- Handshake: readyIn held high for 5 cycles per byte captures exactly one byte, with one triggerOut toggle per byte.
- Pending request:
  - Stimulus: toggle triggerIn once mid-fetch.
  - Response: second fetch starts immediately after DRAIN.
  - Stimulus: toggle twice mid-fetch.
  - Response: no second fetch.
- Reset mid-fetch:
  - Stimulus: assert rst after byte 2.
  - Response: all outputs 0, state IDLE, no readyOut; next fetch at pcIn=0x10 completes normally with pcOut=0x14.
- Wrap: pcIn=0xFFFFFFFC gives addrOut FFFFFFFC..FFFFFFFF and pcOut=0. With FETCH_BIG_ENDIAN_EN, basic fetch gives dataOut=0x01020304.
